// File: rtl/fazyrv_ifetch.sv
// Instruction fetch stage: one Wishbone-classic read per fetch strobe.
// Returns the instruction word, or reports a misaligned, bus-error or timeout fault.
module fazyrv_ifetch #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] RST_INSTR = 32'h13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic        busy_o,
  output logic [31:0] instr_o,
  output logic        instr_vld_o,
  output logic        misalign_o,
  output logic        buserr_o,
  output logic        ibus_cyc_o,
  output logic        ibus_stb_o,
  output logic [31:0] ibus_adr_o,
  input  logic [31:0] ibus_dat_i,
  input  logic        ibus_ack_i,
  input  logic        ibus_err_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Bus handshake: cyc and stb rise together on acceptance and stay high with a
  // stable address until the cycle where ack, err, flush or timeout is seen;
  // they drop on the following edge. err wins over ack when both are high.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_i && !flush_i) begin
          if (pc_i[1:0] == 2'b00) begin
            state_d = BUSY;
            adr_d   = {pc_i[31:2], 2'b00};
            cnt_d   = '0;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // Saturating so a long stall can never wrap back into a false timeout.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (ibus_err_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ibus_ack_i) begin
          instr_d = ibus_dat_i;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      instr_q <= RST_INSTR;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Bus strobes come straight from the state flop so reset drops them at once.
  assign busy_o      = (state_q != IDLE);
  assign ibus_cyc_o  = (state_q == BUSY);
  assign ibus_stb_o  = (state_q == BUSY);
  assign ibus_adr_o  = adr_q;
  assign instr_o     = instr_q;
  assign instr_vld_o = vld_q;
  assign misalign_o  = mis_q;
  assign buserr_o    = err_q;

endmodule

// File: tb/tb_fazyrv_ifetch.sv
// Directed bench for fazyrv_ifetch with TIMEOUT=4; outputs sampled 1 time unit after each rising edge.
module tb_fazyrv_ifetch;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic        flush;
  logic [31:0] pc;
  logic        busy;
  logic [31:0] instr;
  logic        instr_vld;
  logic        misalign;
  logic        buserr;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  fazyrv_ifetch #(.TIMEOUT(4), .RST_INSTR(32'h13)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .fetch_i     (fetch),
    .flush_i     (flush),
    .pc_i        (pc),
    .busy_o      (busy),
    .instr_o     (instr),
    .instr_vld_o (instr_vld),
    .misalign_o  (misalign),
    .buserr_o    (buserr),
    .ibus_cyc_o  (cyc),
    .ibus_stb_o  (stb),
    .ibus_adr_o  (adr),
    .ibus_dat_i  (dat),
    .ibus_ack_i  (ack),
    .ibus_err_i  (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic v, input logic m, input logic e);
    chk({tag, ".vld"}, {31'd0, instr_vld}, {31'd0, v});
    chk({tag, ".mis"}, {31'd0, misalign},  {31'd0, m});
    chk({tag, ".err"}, {31'd0, buserr},    {31'd0, e});
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; flush = 1'b0; pc = '0; dat = '0; ack = 1'b0; err = 1'b0;
    step();
    chk("rst.cyc",   {31'd0, cyc},  32'd0);
    chk("rst.stb",   {31'd0, stb},  32'd0);
    chk("rst.busy",  {31'd0, busy}, 32'd0);
    chk("rst.adr",   adr,   32'h0);
    chk("rst.instr", instr, 32'h13);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Misaligned fetch: pulse, no bus access, instr stays at reset value
    fetch = 1'b1; pc = 32'h0000_0102;
    step();
    fetch = 1'b0;
    chk_pulses("mis", 1'b0, 1'b1, 1'b0);
    chk("mis.cyc",   {31'd0, cyc},  32'd0);
    chk("mis.busy",  {31'd0, busy}, 32'd0);
    chk("mis.instr", instr, 32'h13);
    step();
    chk_pulses("mis.after", 1'b0, 1'b0, 1'b0);

    // Aligned fetch, ack in first BUSY cycle
    fetch = 1'b1; pc = 32'h0000_0100;
    step();
    fetch = 1'b0;
    chk("f1.cyc",  {31'd0, cyc}, 32'd1);
    chk("f1.stb",  {31'd0, stb}, 32'd1);
    chk("f1.adr",  adr, 32'h100);
    chk_pulses("f1.busy", 1'b0, 1'b0, 1'b0);
    ack = 1'b1; dat = 32'h00A0_0513;
    step();
    ack = 1'b0; dat = '0;
    chk("f1.cyc_drop", {31'd0, cyc}, 32'd0);
    chk("f1.instr",    instr, 32'h00A0_0513);
    chk_pulses("f1.done", 1'b1, 1'b0, 1'b0);
    step();
    chk_pulses("f1.after", 1'b0, 1'b0, 1'b0);
    chk("f1.busy_after", {31'd0, busy}, 32'd0);

    // Ack outside BUSY is ignored
    ack = 1'b1; dat = 32'h2222_2222;
    step();
    ack = 1'b0; dat = '0;
    chk_pulses("idle_ack", 1'b0, 1'b0, 1'b0);
    chk("idle_ack.instr", instr, 32'h00A0_0513);

    // Timeout after 4 cycles; fetch_i held in BUSY must not disturb the access
    fetch = 1'b1; pc = 32'h0000_0200;
    step();
    pc = 32'h0000_0400;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.cyc%0d", i), {31'd0, cyc}, 32'd1);
      chk($sformatf("to.adr%0d", i), adr, 32'h200);
      chk_pulses($sformatf("to.wait%0d", i), 1'b0, 1'b0, 1'b0);
      if (i < 3) step();
      else begin
        fetch = 1'b0;
        step();
      end
    end
    chk("to.cyc_drop", {31'd0, cyc}, 32'd0);
    chk_pulses("to.fault", 1'b0, 1'b0, 1'b1);
    // New fetch accepted in the fault cycle
    fetch = 1'b1; pc = 32'h0000_0300;
    step();
    fetch = 1'b0;
    chk("b2b.cyc", {31'd0, cyc}, 32'd1);
    chk("b2b.adr", adr, 32'h300);
    chk_pulses("b2b.busy", 1'b0, 1'b0, 1'b0);
    ack = 1'b1; dat = 32'h1111_1111;
    step();
    ack = 1'b0; dat = '0;
    chk("b2b.instr", instr, 32'h1111_1111);
    chk_pulses("b2b.done", 1'b1, 1'b0, 1'b0);

    // Flush together with ack: data discarded, no pulse
    fetch = 1'b1; pc = 32'h0000_0500;
    step();
    fetch = 1'b0;
    chk("fl.cyc", {31'd0, cyc}, 32'd1);
    flush = 1'b1; ack = 1'b1; dat = 32'hDEAD_BEEF;
    step();
    flush = 1'b0; ack = 1'b0; dat = '0;
    chk("fl.cyc_drop", {31'd0, cyc}, 32'd0);
    chk("fl.busy",     {31'd0, busy}, 32'd0);
    chk("fl.instr",    instr, 32'h1111_1111);
    chk_pulses("fl", 1'b0, 1'b0, 1'b0);
    step();
    chk_pulses("fl.after", 1'b0, 1'b0, 1'b0);

    // Fetch with flush in IDLE is ignored
    fetch = 1'b1; flush = 1'b1; pc = 32'h0000_0102;
    step();
    fetch = 1'b0; flush = 1'b0;
    chk("flfetch.cyc", {31'd0, cyc}, 32'd0);
    chk_pulses("flfetch", 1'b0, 1'b0, 1'b0);

    // Bus error on the third wait cycle
    fetch = 1'b1; pc = 32'h0000_0600;
    step();
    fetch = 1'b0;
    step();
    step();
    chk("be.cyc", {31'd0, cyc}, 32'd1);
    err = 1'b1; ack = 1'b1; dat = 32'h3333_3333;
    step();
    err = 1'b0; ack = 1'b0; dat = '0;
    chk("be.cyc_drop", {31'd0, cyc}, 32'd0);
    chk("be.instr",    instr, 32'h1111_1111);
    chk_pulses("be", 1'b0, 1'b0, 1'b1);
    step();
    chk_pulses("be.after", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-BUSY
    fetch = 1'b1; pc = 32'h0000_0700;
    step();
    fetch = 1'b0;
    chk("ar.cyc_before", {31'd0, cyc}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar.cyc",   {31'd0, cyc},  32'd0);
    chk("ar.stb",   {31'd0, stb},  32'd0);
    chk("ar.busy",  {31'd0, busy}, 32'd0);
    chk("ar.adr",   adr,   32'h0);
    chk("ar.instr", instr, 32'h13);
    step();
    rst = 1'b0;
    step();
    chk("ar.idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
